// File: rtl/dff_bist_ctrl_if.sv
// rtl/dff_bist_ctrl_if.sv - tester-to-flop signal bundle for the mux-D flip-flop BIST
interface dff_bist_ctrl_if;
    logic dut_d0;
    logic dut_d1;
    logic dut_sel;
    logic dut_rst;
    logic dut_q;

    // BIST controller end: drives the flop inputs, observes q
    modport master (
        output dut_d0,
        output dut_d1,
        output dut_sel,
        output dut_rst,
        input  dut_q
    );

    // Flop end: receives stimulus, returns q
    modport slave (
        input  dut_d0,
        input  dut_d1,
        input  dut_sel,
        input  dut_rst,
        output dut_q
    );
endinterface

// File: rtl/dff_bist_ctrl.sv
// rtl/dff_bist_ctrl.sv - directed-vector BIST engine for a mux-D flop; optional DFF_BIST_LFSR_EN randomises sel in reset steps
module dff_bist_ctrl #(
    parameter int unsigned LOOPS        = 1,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    dff_bist_ctrl_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic [2:0]      fail_step
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);
    localparam logic [2:0] LAST_STEP = 3'd6;
    localparam logic [2:0] NO_FAIL   = 3'd7;
    // Idle drive pattern {rst, d0, d1, sel}: hold the flop in reset
    localparam logic [3:0] IDLE_VEC  = 4'b1000;
`ifdef DFF_BIST_LFSR_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
`endif

    // Stimulus table, packed as {rst, d0, d1, sel}
    function automatic logic [3:0] table_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    table_vec = 4'b1110;
            3'd1:    table_vec = 4'b0100;
            3'd2:    table_vec = 4'b1110;
            3'd3:    table_vec = 4'b0011;
            3'd4:    table_vec = 4'b0010;
            3'd5:    table_vec = 4'b0101;
            3'd6:    table_vec = 4'b1110;
            default: table_vec = IDLE_VEC;
        endcase
    endfunction

    // Expected q after the capture of each table step
    function automatic logic table_exp(input logic [2:0] idx);
        case (idx)
            3'd1:    table_exp = 1'b1;
            3'd3:    table_exp = 1'b1;
            default: table_exp = 1'b0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  loop_q, loop_d;
    logic [7:0]  err_q, err_d;
    logic [2:0]  fail_q, fail_d;
    logic        pass_q, pass_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  drive_vec;
    logic        start_acc;
    logic        mismatch;
    logic        last_step;
    logic        last_loop;

    assign start_acc = (state_q == S_IDLE) && start;
    // q is only meaningful one cycle after the capture edge, i.e. in CHECK
    assign mismatch  = (state_q == S_CHECK) && (bus.dut_q != table_exp(step_q));
    assign last_step = (step_q == LAST_STEP);
    assign last_loop = (loop_q == LAST_LOOP);

`ifdef DFF_BIST_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    // LFSR next value: reseed on accepted start, advance once per DRIVE (x^8+x^6+x^5+x^4+1)
    always_comb begin
        lfsr_d = lfsr_q;
        if (start_acc) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == S_DRIVE) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // LFSR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update: step/loop sequencing, error accounting, result
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        loop_d  = loop_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    step_d  = 3'd0;
                    loop_d  = 8'd0;
                    err_d   = 8'd0;
                    fail_d  = NO_FAIL;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (fail_q == NO_FAIL) begin
                        fail_d = step_q;
                    end
                end
                if (mismatch && STOP_ON_FAIL) begin
                    state_d = S_DONE;
                end else if (!last_step) begin
                    state_d = S_DRIVE;
                    step_d  = step_q + 3'd1;
                end else if (!last_loop) begin
                    state_d = S_DRIVE;
                    step_d  = 3'd0;
                    loop_d  = loop_q + 8'd1;
                end else begin
                    state_d = S_DONE;
                end
                // Verdict includes the compare made on this same edge
                if (state_d == S_DONE) begin
                    pass_d = (err_d == 8'd0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output comes straight from a flop
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        drive_vec = table_vec(step_d);
`ifdef DFF_BIST_LFSR_EN
        // Reset steps: sel is randomised; reset must still win over the mux
        if (drive_vec[3]) begin
            drive_vec[0] = lfsr_d[0];
        end
`endif
        case (state_d)
            S_DRIVE: vec_d = drive_vec;
            S_CHECK: vec_d = vec_q;
            default: vec_d = IDLE_VEC;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 3'd0;
            loop_q <= 8'd0;
            err_q  <= 8'd0;
            fail_q <= NO_FAIL;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            vec_q  <= IDLE_VEC;
        end else begin
            step_q <= step_d;
            loop_q <= loop_d;
            err_q  <= err_d;
            fail_q <= fail_d;
            pass_q <= pass_d;
            busy_q <= busy_d;
            done_q <= done_d;
            vec_q  <= vec_d;
        end
    end

    assign bus.dut_rst = vec_q[3];
    assign bus.dut_d0  = vec_q[2];
    assign bus.dut_d1  = vec_q[1];
    assign bus.dut_sel = vec_q[0];

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_step = fail_q;

endmodule
